// File: rtl/nonce_sweeper.sv
// Nonce sweep controller in front of a double-SHA256 core: builds header, launches core, compares hash.
// Latency: per nonce 1 (core reset) + 1 (launch) + core latency + 1 (compare); flags settle 1 cycle after the final compare.
// No backpressure: go is ignored while busy, abort preempts any state, core_done is a level handshake.
module nonce_sweeper #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit NONCE_SWAP     = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic         abort,
    input  logic [607:0] header_prefix,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         busy,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         exhausted,
    output logic         err_timeout,
    output logic [31:0]  cur_nonce,
    output logic         core_rst_n,
    output logic         core_start,
    output logic [639:0] core_block,
    input  logic [255:0] core_hash,
    input  logic         core_done
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CRST    = 3'd1;
    localparam logic [2:0] S_LAUNCH  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_FOUND   = 3'd5;
    localparam logic [2:0] S_EXHAUST = 3'd6;
    localparam logic [2:0] S_TERR    = 3'd7;

    logic [2:0]   state_q,       state_d;
    logic         busy_q,        busy_d;
    logic         found_q,       found_d;
    logic         exh_q,         exh_d;
    logic         err_q,         err_d;
    logic [31:0]  found_nonce_q, found_nonce_d;
    logic [255:0] found_hash_q,  found_hash_d;
    logic [31:0]  cur_nonce_q,   cur_nonce_d;
    logic         core_rst_n_q,  core_rst_n_d;
    logic         core_start_q,  core_start_d;
    logic [607:0] prefix_q,      prefix_d;
    logic [255:0] target_q,      target_d;
    logic [31:0]  end_q,         end_d;
    logic [255:0] hash_q,        hash_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    // Set once a sweep has ended; keeps the core parked in reset while idle.
    logic         swept_q,       swept_d;

    logic [255:0] hash_val;
    logic         hit;
    logic [31:0]  nonce_fld;

    // The core emits the digest in byte order; the numeric value is its byte reversal.
    always_comb begin
        hash_val = '0;
        for (int i = 0; i < 32; i++) begin
            hash_val[8*i +: 8] = hash_q[8*(31-i) +: 8];
        end
    end

    assign hit       = (hash_val <= target_q);
    assign nonce_fld = NONCE_SWAP ? {cur_nonce_q[7:0], cur_nonce_q[15:8],
                                     cur_nonce_q[23:16], cur_nonce_q[31:24]}
                                  : cur_nonce_q;

    // Next-state logic for the sweep FSM; abort overrides every state and drops a coincident go.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        found_d       = found_q;
        exh_d         = exh_q;
        err_d         = err_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        cur_nonce_d   = cur_nonce_q;
        core_rst_n_d  = core_rst_n_q;
        core_start_d  = 1'b0;
        prefix_d      = prefix_q;
        target_d      = target_q;
        end_d         = end_q;
        hash_d        = hash_q;
        cnt_d         = cnt_q;
        swept_d       = swept_q;

        if (abort) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            core_rst_n_d = 1'b0;
            swept_d      = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    core_rst_n_d = ~swept_q;
                    if (go) begin
                        prefix_d     = header_prefix;
                        target_d     = target;
                        end_d        = nonce_end;
                        cur_nonce_d  = nonce_start;
                        found_d      = 1'b0;
                        exh_d        = 1'b0;
                        err_d        = 1'b0;
                        busy_d       = 1'b1;
                        core_rst_n_d = 1'b0;
                        state_d      = S_CRST;
                    end
                end
                S_CRST: begin
                    core_rst_n_d = 1'b1;
                    core_start_d = 1'b1;
                    state_d      = S_LAUNCH;
                end
                S_LAUNCH: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins over a coincident timeout
                    if (core_done) begin
                        hash_d  = core_hash;
                        state_d = S_CHECK;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_TERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        found_nonce_d = cur_nonce_q;
                        found_hash_d  = hash_q;
                        state_d       = S_FOUND;
                    end else if (cur_nonce_q == end_q) begin
                        state_d = S_EXHAUST;
                    end else begin
                        cur_nonce_d  = cur_nonce_q + 32'd1;
                        core_rst_n_d = 1'b0;
                        state_d      = S_CRST;
                    end
                end
                S_FOUND, S_EXHAUST, S_TERR: begin
                    found_d      = found_q | (state_q == S_FOUND);
                    exh_d        = exh_q   | (state_q == S_EXHAUST);
                    err_d        = err_q   | (state_q == S_TERR);
                    busy_d       = 1'b0;
                    core_rst_n_d = 1'b0;
                    swept_d      = 1'b1;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; reset clears everything including the core reset line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exh_q         <= 1'b0;
            err_q         <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            cur_nonce_q   <= '0;
            core_rst_n_q  <= 1'b0;
            core_start_q  <= 1'b0;
            prefix_q      <= '0;
            target_q      <= '0;
            end_q         <= '0;
            hash_q        <= '0;
            cnt_q         <= '0;
            swept_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exh_q         <= exh_d;
            err_q         <= err_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            cur_nonce_q   <= cur_nonce_d;
            core_rst_n_q  <= core_rst_n_d;
            core_start_q  <= core_start_d;
            prefix_q      <= prefix_d;
            target_q      <= target_d;
            end_q         <= end_d;
            hash_q        <= hash_d;
            cnt_q         <= cnt_d;
            swept_q       <= swept_d;
        end
    end

    assign busy        = busy_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign exhausted   = exh_q;
    assign err_timeout = err_q;
    assign cur_nonce   = cur_nonce_q;
    assign core_rst_n  = core_rst_n_q;
    assign core_start  = core_start_q;
    assign core_block  = {prefix_q, nonce_fld};

endmodule

// File: tb/tb_nonce_sweeper.sv
// Bench for nonce_sweeper: directed sweeps against a behavioural SHA core model with a scoreboard.
// Latency: core model asserts done LAT cycles after the start pulse, or never when muted.
// No backpressure: monitor pops expected launches on core_start and expected results on busy falling.
module tb_nonce_sweeper;

    localparam int TO     = 16;
    localparam int LAT    = 5;
    localparam int PERIOD = LAT + 4;

    logic         clk, rst_n, go, abort;
    logic [607:0] header_prefix;
    logic [255:0] target;
    logic [31:0]  nonce_start, nonce_end;
    logic         busy, found, exhausted, err_timeout, core_rst_n, core_start, core_done;
    logic [31:0]  found_nonce, cur_nonce;
    logic [255:0] found_hash, core_hash;
    logic [639:0] core_block;

    nonce_sweeper #(.TIMEOUT_CYCLES(TO), .NONCE_SWAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .header_prefix(header_prefix), .target(target),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .busy(busy), .found(found), .found_nonce(found_nonce), .found_hash(found_hash),
        .exhausted(exhausted), .err_timeout(err_timeout), .cur_nonce(cur_nonce),
        .core_rst_n(core_rst_n), .core_start(core_start), .core_block(core_block),
        .core_hash(core_hash), .core_done(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         f;
        logic         x;
        logic         e;
        logic [31:0]  fn;
        logic [255:0] fh;
    } res_t;

    logic [31:0]  exp_launch_q[$];
    res_t         exp_res_q[$];
    int           errors = 0;
    int           checks = 0;
    int           launch_cnt = 0;
    int           cyc = 0;
    int           last_launch = 0;
    logic         new_sweep = 1'b0;
    logic         prev_busy = 1'b0, prev_crst = 1'b0, prev_err = 1'b0;
    logic [607:0] prefix_exp = '0;
    logic         hit_en = 1'b0, core_mute = 1'b0;
    logic [31:0]  hit_nonce = '0;

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] brev(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
        return r;
    endfunction

    // Numeric hash value the model core produces for a nonce.
    function automatic logic [255:0] model_hv(input logic [31:0] n);
        if (hit_en && n == hit_nonce) return {224'h0, n};
        return {8'hA5, 216'h0, n};
    endfunction

    task automatic chk(input string name, input logic [607:0] act, input logic [607:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural SHA core: reset clears done, start latches the nonce, done after LAT cycles.
    logic [31:0] m_nonce;
    int          m_cnt;
    logic        m_act;
    always @(posedge clk) begin
        if (!core_rst_n) begin
            core_done <= 1'b0;
            core_hash <= '0;
            m_act     <= 1'b0;
            m_cnt     <= 0;
        end else if (core_start) begin
            m_act   <= 1'b1;
            m_cnt   <= LAT;
            m_nonce <= swap32(core_block[31:0]);
        end else if (m_act && !core_done && !core_mute) begin
            if (m_cnt == 1) begin
                core_done <= 1'b1;
                core_hash <= brev(model_hv(m_nonce));
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Monitor: compares each launch and each end-of-sweep against the scoreboard queues.
    always @(negedge clk) begin
        logic [31:0] n;
        res_t        r;
        cyc++;
        if (busy && !prev_busy) new_sweep = 1'b1;
        if (core_start) begin
            launch_cnt++;
            if (exp_launch_q.size() == 0) begin
                chk("launch_unexpected", 608'(core_block[31:0]), 608'(0));
            end else begin
                n = exp_launch_q.pop_front();
                chk("launch_nonce_field", 608'(core_block[31:0]), 608'(swap32(n)));
                chk("launch_cur_nonce", 608'(cur_nonce), 608'(n));
            end
            chk("launch_prefix", core_block[639:32], prefix_exp);
            chk("core_rst_pulse", 608'({prev_crst, core_rst_n}), 608'(2'b01));
            if (!new_sweep) chk("nonce_period", 608'(cyc - last_launch), 608'(PERIOD));
            new_sweep   = 1'b0;
            last_launch = cyc;
        end
        if (err_timeout && !prev_err)
            chk("timeout_latency", 608'(cyc - last_launch), 608'(TO + 2));
        if (prev_busy && !busy) begin
            if (exp_res_q.size() == 0) begin
                chk("result_unexpected", 608'(busy), 608'(1));
            end else begin
                r = exp_res_q.pop_front();
                chk("res_flags", 608'({found, exhausted, err_timeout}), 608'({r.f, r.x, r.e}));
                if (r.f) begin
                    chk("res_found_nonce", 608'(found_nonce), 608'(r.fn));
                    chk("res_found_hash", 608'(found_hash), 608'(r.fh));
                end
            end
        end
        prev_busy = busy;
        prev_crst = core_rst_n;
        prev_err  = err_timeout;
    end

    task automatic push_res(input logic f, input logic x, input logic e, input logic [31:0] fn);
        res_t r;
        r.f = f; r.x = x; r.e = e; r.fn = fn;
        r.fh = brev(model_hv(fn));
        exp_res_q.push_back(r);
    endtask

    task automatic do_go(input logic [607:0] p, input logic [255:0] t,
                         input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        header_prefix = p; target = t; nonce_start = s; nonce_end = e;
        prefix_exp = p;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk(name, 608'(busy), 608'(0));
        @(negedge clk);
    endtask

    task automatic wait_launches(input string name, input int target_cnt, input int budget);
        int k = 0;
        while (launch_cnt < target_cnt && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (launch_cnt < target_cnt) chk(name, 608'(launch_cnt), 608'(target_cnt));
    endtask

    localparam logic [607:0] P1 = {19{32'hC0FFEE01}};
    localparam logic [607:0] P2 = {19{32'h5A5A1234}};
    localparam logic [607:0] P3 = {19{32'h0BADF00D}};

    initial begin
        int base;
        rst_n = 1'b0; go = 1'b0; abort = 1'b0;
        header_prefix = '0; target = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 608'({busy, found, exhausted, err_timeout, core_start, core_rst_n}), 608'(0));
        chk("reset_nonces", 608'({cur_nonce, found_nonce}), 608'(0));
        chk("reset_block", core_block[607:0], 608'(0));
        chk("reset_hash", 608'(found_hash), 608'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("core_rst_release", 608'(core_rst_n), 608'(1));

        // single nonce, all-ones target: hit on 5, nonce field byte-swapped
        hit_en = 1'b0;
        exp_launch_q.push_back(32'h5);
        push_res(1'b1, 1'b0, 1'b0, 32'h5);
        do_go(P1, {256{1'b1}}, 32'h5, 32'h5);
        chk("t1_block_lsw", 608'(core_block[31:0]), 608'(32'h0500_0000));
        wait_idle("t1_idle", 200);
        chk("idle_core_rst_held", 608'(core_rst_n), 608'(0));

        // wrap-around, zero target: 4 launches then exhausted
        base = launch_cnt;
        foreach (exp_launch_q[i]) ;
        exp_launch_q.push_back(32'hFFFF_FFFE);
        exp_launch_q.push_back(32'hFFFF_FFFF);
        exp_launch_q.push_back(32'h0);
        exp_launch_q.push_back(32'h1);
        push_res(1'b0, 1'b1, 1'b0, 32'h0);
        do_go(P2, 256'h0, 32'hFFFF_FFFE, 32'h1);
        wait_idle("t2_idle", 200);
        chk("t2_launches", 608'(launch_cnt - base), 608'(4));

        // hit on 0x1234 with hash_value exactly equal to target
        hit_en = 1'b1; hit_nonce = 32'h1234;
        base = launch_cnt;
        for (int n = 32'h1230; n <= 32'h1234; n++) exp_launch_q.push_back(32'(n));
        push_res(1'b1, 1'b0, 1'b0, 32'h1234);
        do_go(P1, {224'h0, 32'h1234}, 32'h1230, 32'h1240);
        wait_idle("t3_idle", 300);
        chk("t3_launches", 608'(launch_cnt - base), 608'(5));
        chk("t3_busy_low", 608'(busy), 608'(0));

        // target one below hash_value: no hit, single nonce exhausts
        exp_launch_q.push_back(32'h1234);
        push_res(1'b0, 1'b1, 1'b0, 32'h0);
        do_go(P2, {224'h0, 32'h1233}, 32'h1234, 32'h1234);
        wait_idle("t3b_idle", 100);

        // hit on the last nonce reports found, not exhausted
        exp_launch_q.push_back(32'h1233);
        exp_launch_q.push_back(32'h1234);
        push_res(1'b1, 1'b0, 1'b0, 32'h1234);
        do_go(P1, {224'h0, 32'h1234}, 32'h1233, 32'h1234);
        wait_idle("t3c_idle", 100);

        // core never finishes: timeout after TO WAIT cycles
        hit_en = 1'b0; core_mute = 1'b1;
        exp_launch_q.push_back(32'h7);
        push_res(1'b0, 1'b0, 1'b1, 32'h0);
        do_go(P2, {256{1'b1}}, 32'h7, 32'h7);
        wait_idle("t4_idle", 100);
        chk("t4_err", 608'({err_timeout, busy}), 608'(2'b10));
        core_mute = 1'b0;

        // abort during WAIT of the third nonce
        base = launch_cnt;
        exp_launch_q.push_back(32'h100);
        exp_launch_q.push_back(32'h101);
        exp_launch_q.push_back(32'h102);
        push_res(1'b0, 1'b0, 1'b0, 32'h0);
        do_go(P1, 256'h0, 32'h100, 32'h1FF);
        wait_launches("t5_launch_wait", base + 3, 100);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_state", 608'({busy, core_rst_n, core_start, found, exhausted, err_timeout}), 608'(0));

        // abort together with go in idle: go is dropped
        base = launch_cnt;
        @(negedge clk);
        nonce_start = 32'h55; go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_go_idle", 608'({busy, 32'(launch_cnt - base)}), 608'(0));

        // restart after abort uses the new nonce_start
        exp_launch_q.push_back(32'h40);
        push_res(1'b1, 1'b0, 1'b0, 32'h40);
        do_go(P2, {256{1'b1}}, 32'h40, 32'h40);
        wait_idle("t5b_idle", 100);

        // go while busy is ignored, then async reset mid-WAIT
        base = launch_cnt;
        exp_launch_q.push_back(32'h10);
        exp_launch_q.push_back(32'h11);
        push_res(1'b0, 1'b0, 1'b0, 32'h0);
        do_go(P1, 256'h0, 32'h10, 32'h20);
        wait_launches("t6_first", base + 1, 100);
        @(negedge clk);
        header_prefix = P3; nonce_start = 32'h77; target = {256{1'b1}}; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_launches("t6_second", base + 2, 100);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_ctrl", 608'({busy, found, exhausted, err_timeout, core_start, core_rst_n}), 608'(0));
        chk("t6_async_block", core_block[607:0], 608'(0));
        chk("t6_async_nonce", 608'({cur_nonce, found_nonce}), 608'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("launch_queue_empty", 608'(exp_launch_q.size()), 608'(0));
        chk("result_queue_empty", 608'(exp_res_q.size()), 608'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
